multdiv: RTL and testbench
==========================

MULTDIV -- requirements
Module: multdiv

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 Port: clock  in  1  rising-edge clock for all state.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: data_operandA  in  32  multiplicand or dividend, two's complement.
REQ-005 Port: data_operandB  in  32  multiplier or divisor, two's complement.
REQ-006 Port: ctrl_MULT  in  1  one-cycle start pulse for a multiply.
REQ-007 Port: ctrl_DIV  in  1  one-cycle start pulse for a divide.
REQ-008 Port: data_result  out  32  low 32 bits of product, or quotient.
REQ-009 Port: data_exception  out  1  overflow or divide-by-zero flag for data_result.
REQ-010 Port: data_resultRDY  out  1  one-cycle completion pulse.

Function
REQ-011 Operands shall be latched on the clock edge where ctrl_MULT or ctrl_DIV is sampled high; later operand changes are ignored.
REQ-012 If ctrl_MULT and ctrl_DIV are both high on one edge, the block shall start a multiply.
REQ-013 A start pulse while busy shall abort the current operation and restart with the new operands; the aborted operation produces no RDY.
REQ-014 FSM states: IDLE, MUL, DIV, DONE. Transitions: IDLE->MUL/DIV on start, MUL/DIV->DONE after 32 iterations, DONE->IDLE after one cycle, any state->MUL/DIV on start.
REQ-015 Multiply shall be iterative radix-2 shift-add over 32 cycles, with the sign correction applied on the final iteration. The block shall form a 64-bit signed product.
REQ-016 Divide shall be iterative non-restoring division on operand magnitudes over 32 cycles, with the quotient sign applied in DONE.
REQ-017 Latency: with the start sampled on edge N, data_resultRDY shall be high for exactly the cycle following edge N+33. Latency is fixed for all operands, including divide-by-zero.
REQ-018 data_result and data_exception shall update on the same edge RDY rises and hold until the next start or reset.
REQ-019 Multiply: data_result = product[31:0]; data_exception = 1 iff product[63:31] is not all-equal.
REQ-020 Divide: quotient truncates toward zero; the remainder is discarded; data_exception = 0 for normal cases.
REQ-021 Divide by zero: data_result = 0 and data_exception = 1.
REQ-022 0x80000000 / 0xFFFFFFFF: data_result = 0x80000000 and data_exception = 1.
REQ-023 Iteration counter: 6 bits; it shall not wrap past 32.

Reset
REQ-024 While reset is high: state = IDLE; data_result = 0, data_exception = 0, data_resultRDY = 0; counter and internal registers cleared; start pulses ignored.
REQ-025 Reset mid-operation shall discard the operation; no RDY shall follow.

Structure
REQ-026 A shared package shall hold the WIDTH constant, ITERATIONS = 32, and the FSM state enumeration.
REQ-027 One sub-module: multdiv_addsub, a 33-bit add/subtract with carry-in, instanced once and shared by the multiply and divide iterations.

Verification
REQ-028 ctrl_MULT, A=7, B=0xFFFFFFFD (-3) -> RDY one cycle after edge N+33; result 0xFFFFFFEB; exception 0.
REQ-029 ctrl_MULT, A=0x00010000, B=0x00010000 -> result 0x00000000; exception 1.
REQ-030 ctrl_DIV, A=0xFFFFFFEF (-17), B=5 -> result 0xFFFFFFFD (-3); exception 0. Also A=100, B=0 -> result 0; exception 1.
REQ-031 ctrl_MULT 6*7, then ctrl_DIV 9/2 ten cycles later -> no RDY for the multiply; a single RDY 33 cycles after the divide start, with result 4.
REQ-032 ctrl_DIV 0x80000000/0xFFFFFFFF -> result 0x80000000; exception 1.
REQ-033 Reset asserted 20 cycles into a multiply -> no RDY for 40 cycles; outputs stay 0.
REQ-034 Simultaneous ctrl_MULT and ctrl_DIV with A=6, B=3 -> result 18.

Source files
------------

// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared width, iteration count and FSM states for multdiv
package multdiv_pkg;
   localparam int WIDTH = 32;
   localparam int ITERATIONS = 32;
   localparam logic [5:0] LAST_ITER = 6'(ITERATIONS - 1);
   localparam logic [5:0] MAX_ITER = 6'(ITERATIONS);
   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;
endpackage

// File: rtl/multdiv_addsub.sv
// multdiv_addsub: 33-bit adder/subtractor, sub doubles as the carry-in
module multdiv_addsub #(
   parameter int W = 33
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sub,
   output logic [W-1:0] s
);
   assign s = a + (b ^ {W{sub}}) + W'(sub);
endmodule

// File: rtl/multdiv.sv
// multdiv: iterative 32-cycle signed shift-add multiply and non-restoring divide
module multdiv #(
   parameter int WIDTH = multdiv_pkg::WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY
);
   import multdiv_pkg::*;
   state_e           state_q, state_d;
   logic [5:0]       cnt_q, cnt_d;
   logic [WIDTH:0]   acc_q, acc_d;
   logic [WIDTH-1:0] lo_q, lo_d, a_q, a_d, b_q, b_d, res_q, res_d;
   logic             div_q, div_d, exc_q, exc_d, rdy_q, rdy_d;
   logic             start, is_mul, add_sub, neg, div_zero, div_ovf, mul_exc;
   logic [WIDTH-1:0] mag_a, mag_b, div_res;
   logic [WIDTH:0]   add_a, add_b, sum, top_bits;
   multdiv_addsub #(.W(WIDTH + 1)) u_addsub (
      .a  (add_a),
      .b  (add_b),
      .sub(add_sub),
      .s  (sum)
   );
   // Multiply: {acc[31:0], lo} is the product with multiplier bits shifting out of lo;
   // the MSB of the multiplier weighs -2^31, so the last step subtracts.
   // Divide: {acc, lo} is remainder:dividend; quotient bits shift into lo.
   always_comb begin
      start    = ctrl_MULT | ctrl_DIV;
      is_mul   = state_q == MUL;
      mag_a    = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
      mag_b    = b_q[WIDTH-1] ? -b_q : b_q;
      add_a    = is_mul ? {acc_q[WIDTH-1], acc_q[WIDTH-1:0]} : {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
      add_b    = is_mul ? (lo_q[0] ? {a_q[WIDTH-1], a_q} : '0) : {1'b0, mag_b};
      add_sub  = is_mul ? cnt_q == LAST_ITER : ~acc_q[WIDTH];
      top_bits = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
      mul_exc  = ~(&top_bits | ~|top_bits);
      neg      = a_q[WIDTH-1] ^ b_q[WIDTH-1];
      div_zero = b_q == '0;
      div_ovf  = a_q == {1'b1, {(WIDTH-1){1'b0}}} && b_q == '1;
      div_res  = div_zero ? '0 : neg ? -lo_q : lo_q;
   end
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      lo_d    = lo_q;
      a_d     = a_q;
      b_d     = b_q;
      div_d   = div_q;
      res_d   = res_q;
      exc_d   = exc_q;
      rdy_d   = 1'b0;
      if (start) begin
         state_d = ctrl_MULT ? MUL : DIV;
         div_d   = ~ctrl_MULT;
         cnt_d   = '0;
         a_d     = data_operandA;
         b_d     = data_operandB;
         acc_d   = '0;
         lo_d    = ctrl_MULT ? data_operandB : mag_a;
      end else begin
         unique case (state_q)
            MUL, DIV: begin
               acc_d   = is_mul ? {sum[WIDTH], sum[WIDTH:1]} : sum;
               lo_d    = is_mul ? {sum[0], lo_q[WIDTH-1:1]} : {lo_q[WIDTH-2:0], ~sum[WIDTH]};
               cnt_d   = cnt_q == MAX_ITER ? cnt_q : cnt_q + 6'd1;
               state_d = cnt_q == LAST_ITER ? DONE : state_q;
            end
            DONE: begin
               state_d = IDLE;
               rdy_d   = 1'b1;
               res_d   = div_q ? div_res : lo_q;
               exc_d   = div_q ? div_zero | div_ovf : mul_exc;
            end
            default: ;
         endcase
      end
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         lo_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         div_q   <= 1'b0;
         res_q   <= '0;
         exc_q   <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         lo_q    <= lo_d;
         a_q     <= a_d;
         b_q     <= b_d;
         div_q   <= div_d;
         res_q   <= res_d;
         exc_q   <= exc_d;
         rdy_q   <= rdy_d;
      end
   end
   assign data_result    = res_q;
   assign data_exception = exc_q;
   assign data_resultRDY = rdy_q;
endmodule

// File: tb/tb_multdiv.sv
// tb_multdiv: directed vectors with a scoreboard queue checked by an RDY monitor
module tb_multdiv;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] data_operandA = '0;
   logic [31:0] data_operandB = '0;
   logic        ctrl_MULT = 1'b0;
   logic        ctrl_DIV = 1'b0;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;
   typedef struct {
      logic [31:0] res;
      logic        exc;
      int          cyc;
      string       name;
   } exp_t;
   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [31:0] last_res = '0;
   multdiv dut (
      .clock         (clock),
      .reset         (reset),
      .data_operandA (data_operandA),
      .data_operandB (data_operandB),
      .ctrl_MULT     (ctrl_MULT),
      .ctrl_DIV      (ctrl_DIV),
      .data_result   (data_result),
      .data_exception(data_exception),
      .data_resultRDY(data_resultRDY)
   );
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;
   task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask
   always @(negedge clock) begin
      if (data_resultRDY !== 1'b0) begin
         if (sb.size() == 0) begin
            check("unexpected_rdy", {31'b0, data_resultRDY}, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, "_result"}, data_result, e.res);
            check({e.name, "_exception"}, {31'b0, data_exception}, {31'b0, e.exc});
            check({e.name, "_latency"}, cyc, e.cyc);
         end
      end
   end
   task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input logic x, input bit expect_it, input string n);
      @(negedge clock);
      ctrl_MULT     = m;
      ctrl_DIV      = d;
      data_operandA = a;
      data_operandB = b;
      if (expect_it) begin
         sb.push_back('{r, x, cyc + 34, n});
         last_res = r;
      end
      @(negedge clock);
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
   endtask
   task automatic drain();
      for (int i = 0; i < 80 && sb.size() > 0; i++) @(negedge clock);
      check("drain_timeout", sb.size(), 0);
      sb.delete();
      repeat (3) @(negedge clock);
      check("result_hold", data_result, last_res);
   endtask
   initial begin
      repeat (3) @(negedge clock);
      check("reset_result", data_result, 32'd0);
      check("reset_exception", {31'b0, data_exception}, 32'd0);
      check("reset_rdy", {31'b0, data_resultRDY}, 32'd0);
      reset = 1'b0;
      issue(1, 0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 0, 1, "mul_7_m3");       drain();
      issue(1, 0, 32'h00010000, 32'h00010000, 32'h00000000, 1, 1, "mul_ovf");        drain();
      issue(0, 1, 32'hFFFFFFEF, 32'd5,        32'hFFFFFFFD, 0, 1, "div_m17_5");      drain();
      issue(0, 1, 32'd100,      32'd0,        32'h00000000, 1, 1, "div_by_zero");    drain();
      issue(0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1, "div_ovf");        drain();
      issue(1, 1, 32'd6,        32'd3,        32'd18,       0, 1, "both_start");     drain();
      issue(1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        0, 1, "mul_m1_m1");      drain();
      issue(1, 0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1, "mul_min_m1");     drain();
      issue(1, 0, 32'h7FFFFFFF, 32'd2,        32'hFFFFFFFE, 1, 1, "mul_max_2");      drain();
      issue(0, 1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 0, 1, "div_7_m2");       drain();
      issue(0, 1, 32'h80000000, 32'd1,        32'h80000000, 0, 1, "div_min_1");      drain();
      issue(0, 1, 32'd3,        32'd7,        32'd0,        0, 1, "div_3_7");        drain();
      issue(1, 0, 32'd6,        32'd7,        32'd42,       0, 0, "mul_aborted");
      repeat (8) @(negedge clock);
      issue(0, 1, 32'd9,        32'd2,        32'd4,        0, 1, "div_after_abort"); drain();
      issue(1, 0, 32'd5,        32'd5,        32'd25,       0, 0, "mul_reset");
      repeat (18) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      ctrl_MULT = 1'b1;
      @(negedge clock);
      ctrl_MULT = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         check("post_reset_outputs", {data_result[31:1], data_result[0] | data_exception | data_resultRDY}, 32'd0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
